// File: rtl/count_seq_ctrl_if.sv
// Control/status bundle for count_seq_ctrl.
// The master drives the run controls; the slave (the counter) returns the count and status flags.
interface count_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             mode_repeat;
    logic             hold;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tick;
    logic             done;

    modport master (
        output start, load_val, mode_repeat, hold, stop,
        input  q, busy, tick, done
    );

    modport slave (
        input  start, load_val, mode_repeat, hold, stop,
        output q, busy, tick, done
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Run-controlled up-counter with terminal count, optional auto-restart, hold and abort.
// Count and state are registered; tick is combinational off state/q/hold; done decodes the DONE state.
module count_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    count_seq_ctrl_if.slave io
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             rep_q, rep_d;
    logic             tick;

    assign tick = (state_q == RUN) && !io.hold && (q_q == limit_q);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        limit_d = limit_q;
        rep_d   = rep_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    q_d = '0;
                    if (io.load_val != '0) begin
                        limit_d = io.load_val;
                        rep_d   = io.mode_repeat;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // stop beats hold beats terminal count beats increment
                if (io.stop) begin
                    q_d     = '0;
                    state_d = IDLE;
                end else if (io.hold) begin
                    state_d = HOLD;
                end else if (tick) begin
                    if (rep_q) begin
                        q_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            HOLD: begin
                if (io.stop) begin
                    q_d     = '0;
                    state_d = IDLE;
                end else if (!io.hold) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (io.stop) begin
                    q_d = '0;
                end
                state_d = IDLE;
            end
            default: begin
                q_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            limit_q <= '0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            limit_q <= limit_d;
            rep_q   <= rep_d;
        end
    end

    assign io.q    = q_q;
    assign io.busy = (state_q == RUN) || (state_q == HOLD);
    assign io.done = (state_q == DONE);
    assign io.tick = tick;
endmodule
